// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: loads the program into instruction memory, then runs it
// continuously or one step at a time until the halt word is fetched.
// Optional macro CYCLE_COUNTER_EN enables the enabled-fetch cycle counter.
module fetch_sequencer #(
    parameter int             len       = 32,
    parameter int             IM_ADDR_W = 10,
    parameter logic [len-1:0] HALT_WORD = len'(32'hFFFFFFFF)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load_valid,
    input  logic [len-1:0]       i_load_data,
    output logic                 o_load_ready,
    input  logic                 i_start,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    input  logic                 i_reload,
    input  logic                 i_stall,
    input  logic [len-1:0]       i_instruccion,
    output logic                 o_im_we,
    output logic [IM_ADDR_W-1:0] o_im_waddr,
    output logic [len-1:0]       o_im_wdata,
    output logic                 o_pc_en,
    output logic                 o_pc_clr,
    output logic                 o_halted,
    output logic [1:0]           o_state,
    output logic [31:0]          o_cycle_count
);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_READY  = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [IM_ADDR_W-1:0] PTR_MAX = '1;

    state_t               r_state;
    state_t               w_next;
    logic [IM_ADDR_W-1:0] r_ptr;
    logic                 r_pc_clr;
    logic                 r_halted;
    logic                 w_pc_en;
    logic                 w_load_ready;
    logic                 w_im_we;
    logic                 w_load_done;

    always_comb begin
        w_next       = r_state;
        w_pc_en      = 1'b0;
        w_load_ready = 1'b0;
        w_im_we      = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                w_load_ready = 1'b1;
                w_im_we      = i_load_valid;
                if (i_load_valid && (i_load_data == HALT_WORD || r_ptr == PTR_MAX))
                    w_next = S_READY;
            end
            S_READY: begin
                if (i_start)
                    w_next = i_step_mode ? S_STEP : S_RUN;
            end
            S_RUN: begin
                if (!i_stall) begin
                    if (i_instruccion == HALT_WORD)
                        w_next = S_HALTED;
                    else
                        w_pc_en = 1'b1;
                end
            end
            S_STEP: begin
                // A step arriving under a stall is dropped rather than remembered.
                if (i_step && !i_stall) begin
                    if (i_instruccion == HALT_WORD)
                        w_next = S_HALTED;
                    else
                        w_pc_en = 1'b1;
                end
            end
            S_HALTED: begin
                if (i_reload)
                    w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end

    assign w_load_done = (r_state == S_LOAD) && (w_next == S_READY);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_LOAD;
            r_ptr    <= '0;
            r_pc_clr <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_pc_clr <= w_load_done;
            r_halted <= (w_next == S_HALTED);
            // Pointer saturates at the last word so a full memory is never overwritten.
            if (r_state == S_LOAD && i_load_valid && r_ptr != PTR_MAX)
                r_ptr <= r_ptr + 1'b1;
            else if (r_state == S_HALTED && i_reload)
                r_ptr <= '0;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cycle_count <= '0;
        else if (w_load_done)
            r_cycle_count <= '0;
        else if (w_pc_en && r_cycle_count != 32'hFFFFFFFF)
            r_cycle_count <= r_cycle_count + 32'd1;
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = 32'd0;
`endif

    // HALTED shares the READY encoding; o_halted tells them apart.
    always_comb begin
        unique case (r_state)
            S_LOAD:   o_state = 2'd0;
            S_READY:  o_state = 2'd1;
            S_RUN:    o_state = 2'd2;
            S_STEP:   o_state = 2'd3;
            S_HALTED: o_state = 2'd1;
            default:  o_state = 2'd0;
        endcase
    end

    assign o_load_ready = w_load_ready;
    assign o_im_we      = w_im_we;
    assign o_im_waddr   = r_ptr;
    assign o_im_wdata   = i_load_data;
    assign o_pc_en      = w_pc_en;
    assign o_pc_clr     = r_pc_clr;
    assign o_halted     = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed per-cycle vectors with expected
// outputs queued by the drivers and checked by a negedge monitor.
module tb_fetch_sequencer;

    localparam logic [31:0] H = 32'hFFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (IM_ADDR_W = 10)
    logic        rst, lv, st, sm, sp, rl, sl;
    logic [31:0] ld, ins;
    logic        o_lr, o_we, o_pe, o_clr, o_h;
    logic [9:0]  o_wa;
    logic [31:0] o_wd, o_cnt;
    logic [1:0]  o_st;

    fetch_sequencer #(.len(32), .IM_ADDR_W(10)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_load_valid(lv), .i_load_data(ld),
        .o_load_ready(o_lr), .i_start(st), .i_step_mode(sm), .i_step(sp),
        .i_reload(rl), .i_stall(sl), .i_instruccion(ins), .o_im_we(o_we),
        .o_im_waddr(o_wa), .o_im_wdata(o_wd), .o_pc_en(o_pe), .o_pc_clr(o_clr),
        .o_halted(o_h), .o_state(o_st), .o_cycle_count(o_cnt)
    );

    // small instance (IM_ADDR_W = 2) for the full-memory case
    logic        s_rst, s_lv;
    logic [31:0] s_ld;
    logic        s_lr, s_we, s_pe, s_clr, s_h;
    logic [1:0]  s_wa, s_st;
    logic [31:0] s_wd, s_cnt;

    fetch_sequencer #(.len(32), .IM_ADDR_W(2)) u_small (
        .i_clk(clk), .i_rst(s_rst), .i_load_valid(s_lv), .i_load_data(s_ld),
        .o_load_ready(s_lr), .i_start(1'b0), .i_step_mode(1'b0), .i_step(1'b0),
        .i_reload(1'b0), .i_stall(1'b0), .i_instruccion(32'd0), .o_im_we(s_we),
        .o_im_waddr(s_wa), .o_im_wdata(s_wd), .o_pc_en(s_pe), .o_pc_clr(s_clr),
        .o_halted(s_h), .o_state(s_st), .o_cycle_count(s_cnt)
    );

    typedef struct packed {
        logic        lr, we;
        logic [9:0]  wa;
        logic [31:0] wd;
        logic        pe, clr, h;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    typedef struct packed {
        logic        lr, we;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic        clr;
        logic [1:0]  st;
    } sexp_t;

    exp_t  q[$];
    sexp_t sq[$];
    int    nvec = 0;
    int    nmis = 0;

    function automatic exp_t E(logic lr_, logic we_, logic [9:0] wa_, logic [31:0] wd_,
                               logic pe_, logic clr_, logic h_, logic [1:0] st_,
                               logic [31:0] cnt_);
        exp_t e;
        e.lr = lr_; e.we = we_; e.wa = wa_; e.wd = wd_; e.pe = pe_;
        e.clr = clr_; e.h = h_; e.st = st_;
`ifdef CYCLE_COUNTER_EN
        e.cnt = cnt_;
`else
        e.cnt = 32'd0;
`endif
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] x);
        if (a !== x) begin
            nmis++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, x);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            chk("load_ready", 32'(o_lr), 32'(e.lr));
            chk("im_we", 32'(o_we), 32'(e.we));
            chk("im_waddr", 32'(o_wa), 32'(e.wa));
            if (e.we) chk("im_wdata", o_wd, e.wd);
            chk("pc_en", 32'(o_pe), 32'(e.pe));
            chk("pc_clr", 32'(o_clr), 32'(e.clr));
            chk("halted", 32'(o_h), 32'(e.h));
            chk("state", 32'(o_st), 32'(e.st));
            chk("cycle_count", o_cnt, e.cnt);
        end
        if (sq.size() > 0) begin
            sexp_t s;
            s = sq.pop_front();
            nvec++;
            chk("s_load_ready", 32'(s_lr), 32'(s.lr));
            chk("s_im_we", 32'(s_we), 32'(s.we));
            chk("s_im_waddr", 32'(s_wa), 32'(s.wa));
            if (s.we) chk("s_im_wdata", s_wd, s.wd);
            chk("s_pc_clr", 32'(s_clr), 32'(s.clr));
            chk("s_state", 32'(s_st), 32'(s.st));
        end
    end

    task automatic v(logic lv_, logic [31:0] ld_, logic st_, logic sm_, logic sp_,
                     logic rl_, logic sl_, logic [31:0] ins_, exp_t e);
        lv = lv_; ld = ld_; st = st_; sm = sm_; sp = sp_; rl = rl_; sl = sl_; ins = ins_;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic sv(logic lv_, logic [31:0] ld_, logic lr_, logic we_, logic [1:0] wa_,
                      logic clr_, logic [1:0] st_);
        sexp_t s;
        s_lv = lv_; s_ld = ld_;
        s.lr = lr_; s.we = we_; s.wa = wa_; s.wd = ld_; s.clr = clr_; s.st = st_;
        sq.push_back(s);
        @(posedge clk); #1;
    endtask

    initial begin
        s_rst = 1'b1; s_lv = 1'b0; s_ld = '0;
        @(posedge clk); #1;
        sv(1, 32'h0000000A, 1, 1, 0, 0, 0);
        s_rst = 1'b0;
        sv(1, 32'h00000001, 1, 1, 0, 0, 0);
        sv(1, 32'h00000002, 1, 1, 1, 0, 0);
        sv(1, 32'h00000003, 1, 1, 2, 0, 0);
        sv(1, 32'h00000004, 1, 1, 3, 0, 0);
        sv(1, 32'h00000005, 0, 0, 3, 1, 1);
        sv(1, 32'h00000006, 0, 0, 3, 0, 1);
        s_lv = 1'b0;
    end

    initial begin
        rst = 1'b1; lv = 0; ld = '0; st = 0; sm = 0; sp = 0; rl = 0; sl = 0; ins = '0;
        @(posedge clk); #1;
        // reset values, write port follows inputs
        v(1, 32'h000000A5, 0,0,0,0,0, 0, E(1,1,0,32'hA5,0,0,0,0,0));
        rst = 1'b0;
        v(0, 0,            0,0,0,0,0, 0, E(1,0,0,0,0,0,0,0,0));
        // three-word program
        v(1, 32'h20010005, 0,0,0,0,0, 0, E(1,1,0,32'h20010005,0,0,0,0,0));
        v(1, 32'h20020007, 0,0,0,0,0, 0, E(1,1,1,32'h20020007,0,0,0,0,0));
        v(1, H,            0,0,0,0,0, 0, E(1,1,2,H,0,0,0,0,0));
        v(0, 0,            0,0,0,0,0, 0, E(0,0,3,0,0,1,0,1,0));
        v(1, 32'hDEADBEEF, 0,0,0,0,0, 0, E(0,0,3,0,0,0,0,1,0));
        // start RUN with a simultaneous step
        v(0, 0, 1,0,1,0,0, 0,            E(0,0,3,0,0,0,0,1,0));
        v(0, 0, 0,0,0,0,0, 32'h20010005, E(0,0,3,0,1,0,0,2,0));
        v(0, 0, 0,0,0,0,0, 32'h20020007, E(0,0,3,0,1,0,0,2,1));
        v(0, 0, 0,0,0,0,1, 32'h20020007, E(0,0,3,0,0,0,0,2,2));
        v(0, 0, 0,0,0,0,1, 32'h20020007, E(0,0,3,0,0,0,0,2,2));
        v(0, 0, 0,0,0,0,0, 32'h20020007, E(0,0,3,0,1,0,0,2,2));
        v(0, 0, 0,0,0,0,0, 32'h12345678, E(0,0,3,0,1,0,0,2,3));
        v(0, 0, 0,0,0,0,1, H,            E(0,0,3,0,0,0,0,2,4));
        v(0, 0, 0,0,0,0,0, H,            E(0,0,3,0,0,0,0,2,4));
        v(0, 0, 1,0,1,0,0, 0,            E(0,0,3,0,0,0,1,1,4));
        v(0, 0, 0,0,0,1,0, 0,            E(0,0,3,0,0,0,1,1,4));
        // reload: writes restart at 0
        v(0, 0,            0,0,0,0,0, 0, E(1,0,0,0,0,0,0,0,4));
        v(1, 32'h11111111, 0,0,0,0,0, 0, E(1,1,0,32'h11111111,0,0,0,0,4));
        v(1, H,            0,0,0,0,0, 0, E(1,1,1,H,0,0,0,0,4));
        v(0, 0,            0,0,0,0,0, 0, E(0,0,2,0,0,1,0,1,0));
        // STEP mode: step with start ignored, one step lost to a stall
        v(0, 0, 1,1,1,0,0, 0,            E(0,0,2,0,0,0,0,1,0));
        v(0, 0, 0,0,0,0,0, 32'h11111111, E(0,0,2,0,0,0,0,3,0));
        v(0, 0, 0,0,1,0,0, 32'h11111111, E(0,0,2,0,1,0,0,3,0));
        v(0, 0, 0,0,0,0,0, 32'h22222222, E(0,0,2,0,0,0,0,3,1));
        v(0, 0, 0,0,1,0,1, 32'h22222222, E(0,0,2,0,0,0,0,3,1));
        v(0, 0, 0,0,0,0,0, 32'h22222222, E(0,0,2,0,0,0,0,3,1));
        v(0, 0, 0,0,1,0,0, 32'h22222222, E(0,0,2,0,1,0,0,3,1));
        v(0, 0, 0,0,0,0,0, H,            E(0,0,2,0,0,0,0,3,2));
        v(0, 0, 0,0,1,0,0, H,            E(0,0,2,0,0,0,0,3,2));
        v(0, 0, 0,0,0,0,0, 0,            E(0,0,2,0,0,0,1,1,2));
        v(0, 0, 0,0,0,1,0, 0,            E(0,0,2,0,0,0,1,1,2));
        // short program, RUN, then asynchronous reset mid-cycle
        v(1, H, 0,0,0,0,0, 0,            E(1,1,0,H,0,0,0,0,2));
        v(0, 0, 0,0,0,0,0, 0,            E(0,0,1,0,0,1,0,1,0));
        v(0, 0, 1,0,0,0,0, 0,            E(0,0,1,0,0,0,0,1,0));
        v(0, 0, 0,0,0,0,0, 32'h20010005, E(0,0,1,0,1,0,0,2,0));
        v(0, 0, 0,0,0,0,0, 32'h20010005, E(0,0,1,0,1,0,0,2,1));
        rst = 1'b1;
        v(0, 0, 0,0,0,0,0, 32'h20010005, E(1,0,0,0,0,0,0,0,0));
        rst = 1'b0;
        v(1, 32'h33333333, 0,0,0,0,0, 0, E(1,1,0,32'h33333333,0,0,0,0,0));
        v(0, 0,            0,0,0,0,0, 0, E(1,0,1,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        if (q.size() != 0 || sq.size() != 0) begin
            nmis++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q.size(), sq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block for the MIPS instruction fetch stage. It loads a program word by word into instruction memory, then clears the PC and releases fetch in either continuous or single-step mode. It gates PC updates with the hazard-unit stall and stops fetch when the halt word reaches the fetch output. It sits between the debug/loader front end and `tl_instruction_fetch`, driving that block's memory write port and PC enable/clear.

## Interface
- `len`, 32, data/instruction width
- `IM_ADDR_W`, 10, instruction memory word-address width (depth 2^IM_ADDR_W)
- `HALT_WORD`, 32'hFFFFFFFF, program terminator / halt instruction
- `i_clk` in 1: single clock, rising edge
- `i_rst` in 1: asynchronous, active-high reset
- `i_load_valid` in 1: loader offers `i_load_data`
- `i_load_data` in len: program word
- `o_load_ready` out 1: word accepted when valid & ready
- `i_start` in 1: one-cycle pulse, leaves READY
- `i_step_mode` in 1: level, sampled with `i_start`; 1 = single-step
- `i_step` in 1: one-cycle pulse, advance one instruction in STEP
- `i_reload` in 1: one-cycle pulse, HALTED -> LOAD
- `i_stall` in 1: hazard stall, holds PC
- `i_instruccion` in len: current fetch-stage instruction
- `o_im_we` out 1: instruction memory write enable
- `o_im_waddr` out IM_ADDR_W: write word address
- `o_im_wdata` out len: write data
- `o_pc_en` out 1: PC register update enable
- `o_pc_clr` out 1: synchronous PC clear pulse
- `o_halted` out 1: program reached halt
- `o_state` out 2: LOAD=0, READY=1, RUN=2, STEP=3 (HALTED reported as 1 with `o_halted`=1)
- `o_cycle_count` out 32: enabled fetch cycles

## Operation
- States: LOAD, READY, RUN, STEP, HALTED. Reset enters LOAD.
- LOAD:
  - `o_load_ready`=1.
  - `o_im_we` = `i_load_valid`; `o_im_wdata` = `i_load_data`; `o_im_waddr` = write pointer.
  - Each accepted word increments the pointer.
  - The state moves to READY when the accepted word equals `HALT_WORD` (the halt word itself is written) or when the pointer is at 2^IM_ADDR_W-1 (full; pointer does not wrap).
- READY:
  - `o_pc_clr`=1 for exactly the first cycle in READY.
  - On `i_start`: go to STEP if `i_step_mode`=1, else RUN.
  - A simultaneous `i_step` is ignored.
- RUN:
  - `o_pc_en` = ~`i_stall`.
  - If `i_instruccion`==`HALT_WORD` and ~`i_stall`: `o_pc_en`=0 that cycle and the state moves to HALTED.
- STEP:
  - `o_pc_en` = `i_step` & ~`i_stall`.
  - A step pulse during a stall is dropped, not queued.
  - Halt detection is as in RUN, qualified by `i_step`.
- HALTED:
  - `o_halted`=1; `o_pc_en`=0.
  - `i_reload` returns to LOAD with the write pointer at 0.
- `o_cycle_count` increments in every cycle with `o_pc_en`=1 and saturates at 2^32-1. It clears on the LOAD->READY transition.
- All other inputs are ignored in states where they have no listed effect.

## Timing
- Reset values:
  - state LOAD, pointer 0
  - `o_load_ready`=1, `o_state`=0
  - `o_im_we`, `o_im_waddr`, `o_im_wdata` follow inputs: `o_im_we`=`i_load_valid`, `o_im_waddr`=0, `o_im_wdata`=`i_load_data`
  - `o_pc_en`=0, `o_pc_clr`=0, `o_halted`=0
  - `o_cycle_count`=0
- `o_im_we`, `o_im_wdata`, `o_pc_en` are combinational from state and inputs (same-cycle).
- `o_pc_clr`, `o_halted`, `o_state`, the pointer and `o_cycle_count` are registered.
- LOAD accepts one word per cycle. The last accepted word's cycle is the final LOAD cycle; READY begins the next edge.
- `i_start` in cycle N means RUN/STEP in cycle N+1. In RUN, the first `o_pc_en`=1 is in cycle N+1.
- Halt: `o_pc_en` is 0 in the cycle the halt word is seen, and `o_halted`=1 from the next cycle.
- Asserting `i_rst` in any state immediately (asynchronously) restores the reset values. Memory contents are untouched.

## Configuration
- `CYCLE_COUNTER_EN` defined: the counter is implemented as described.
- Undefined: no counter register; `o_cycle_count` is tied to 0.

## Test plan
- Load 3 words (0x20010005, 0x20020007, HALT_WORD) back-to-back after reset.
  - Required: writes to addresses 0,1,2; READY on the 4th cycle; `o_pc_clr` high for 1 cycle.
- Load full memory with IM_ADDR_W=2: 4 words, none the halt word, and a 5th valid word.
  - Required: READY after the 4th; the 5th is not written (`o_load_ready`=0).
- Start in RUN with `i_stall` high for 2 cycles in the middle.
  - Required: `o_pc_en` low for exactly those 2 cycles.
  - Required: halt word at fetch gives `o_pc_en`=0 and `o_halted`=1 next cycle; `o_cycle_count` equals the enabled cycles.
- STEP mode with 3 `i_step` pulses, one coinciding with `i_stall`.
  - Required: exactly 2 `o_pc_en` pulses; `i_step` issued together with `i_start` is ignored.
- Reset asserted mid-RUN, then `i_reload` in HALTED.
  - Required: immediate return to LOAD with all reset values; after reload, loading starts again at address 0.
- Build without `CYCLE_COUNTER_EN`.
  - Required: `o_cycle_count`=0 throughout the RUN scenario.
